// File: rtl/music_box_pkg.sv
// ----------------------------------------------------------------------------
// music_box_pkg
//
// Shared definitions for the music box audio path.
//
// Contents:
//   dac_state_t      - states of the DAC SPI driver FSM
//   DAC_CH_A         - frame bit 15, selects DAC channel A
//   DAC_GAIN_1X      - frame bit 13, selects 1x output gain
//   DAC_ACTIVE       - frame bit 12, keeps the DAC output active
//   AUDIO_MIDSCALE   - the silent level of an unsigned 8-bit sample
//   buildDacFrame()  - assembles the 16-bit command word for one sample
// ----------------------------------------------------------------------------
package music_box_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        LDAC  = 3'd4
    } dac_state_t;

    localparam logic DAC_CH_A    = 1'b0;
    localparam logic DAC_GAIN_1X = 1'b1;
    localparam logic DAC_ACTIVE  = 1'b1;

    localparam logic [7:0] AUDIO_MIDSCALE = 8'h80;

    // The 8-bit sample sits in the top of the 12-bit DAC code, so the low
    // four code bits are always zero and full-scale maps to 0xFF0.
    function automatic logic [15:0] buildDacFrame(input logic [7:0] sample,
                                                  input logic       bufBit);
        return {DAC_CH_A, bufBit, DAC_GAIN_1X, DAC_ACTIVE, sample, 4'b0000};
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// ----------------------------------------------------------------------------
// sync_rise_detect
//
// Brings an asynchronous level into the clock_50Mhz domain through a two
// flop synchroniser and produces a registered one-cycle pulse for every
// rising edge of that level. Used for the sample clock here and intended
// for the buttons and other slow inputs of the music box as well.
//
// Ports:
//   clock_50Mhz  in   system clock
//   reset_n      in   asynchronous active-low reset
//   asyncIn      in   level from another clock domain or a pin
//   risePulse    out  one-cycle high pulse, three cycles after asyncIn rises
// ----------------------------------------------------------------------------
module sync_rise_detect (
    input  logic clock_50Mhz,
    input  logic reset_n,
    input  logic asyncIn,
    output logic risePulse
);

    logic syncStage1;
    logic syncStage2;
    logic prevLevel;

    // Two flops for metastability settling, a third holding the previous
    // settled value, and the pulse itself registered so the consumer never
    // sees a combinational path from the pin.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            syncStage1 <= 1'b0;
            syncStage2 <= 1'b0;
            prevLevel  <= 1'b0;
            risePulse  <= 1'b0;
        end else begin
            syncStage1 <= asyncIn;
            syncStage2 <= syncStage1;
            prevLevel  <= syncStage2;
            risePulse  <= syncStage2 & ~prevLevel;
        end
    end

endmodule

// File: rtl/audio_dac_spi_driver.sv
// ----------------------------------------------------------------------------
// audio_dac_spi_driver
//
// Takes the 8-bit unsigned sample from the music box state controller,
// captures it on every rising edge of the 22 kHz sample clock and sends it
// to an external single-channel 12-bit DAC as one 16-bit SPI mode 0 frame,
// MSB first, followed by an LDAC strobe that makes the new code take effect.
//
// Parameters:
//   CLK_DIV     SCLK half period in clock_50Mhz cycles (>= 2)
//   CS_SETUP    cycles from dac_cs_n low to the first SCLK rise (>= 1)
//   CS_HOLD     cycles from the last SCLK fall to dac_cs_n high (>= 1)
//   LDAC_WIDTH  dac_ldac_n low pulse width in cycles (>= 1)
//   BUF_BIT     frame bit 14, DAC reference buffer enable
//
// Ports:
//   clock_50Mhz    in   system clock, sole clock of the block
//   reset_n        in   asynchronous active-low reset
//   clock_22Khz    in   sample-rate clock, treated as data
//   sample_in      in   8-bit unsigned audio sample, 0x80 is silence
//   mute           in   forces the captured sample to mid-scale
//   dac_sclk       out  SPI clock, idles low
//   dac_mosi       out  SPI data
//   dac_cs_n       out  DAC chip select, active low
//   dac_ldac_n     out  DAC latch strobe, active low
//   busy           out  high whenever a frame is in progress
//   overrun_count  out  number of samples dropped, saturates at 255
// ----------------------------------------------------------------------------
module audio_dac_spi_driver
    import music_box_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int LDAC_WIDTH = 2,
    parameter bit BUF_BIT    = 1'b0
) (
    input  logic       clock_50Mhz,
    input  logic       reset_n,
    input  logic       clock_22Khz,
    input  logic [7:0] sample_in,
    input  logic       mute,
    output logic       dac_sclk,
    output logic       dac_mosi,
    output logic       dac_cs_n,
    output logic       dac_ldac_n,
    output logic       busy,
    output logic [7:0] overrun_count
);

    // One down-counter times every phase; it is loaded with the phase
    // length minus one and the phase ends on the cycle it reads zero.
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] LDAC_LOAD  = CNT_W'(LDAC_WIDTH - 1);

    localparam logic [3:0] LAST_BIT = 4'd15;

    dac_state_t       state;
    logic [CNT_W-1:0] downCount;
    logic [3:0]       bitCount;
    logic [15:0]      shiftReg;

    logic             tick;
    logic [7:0]       pendingSample;
    logic             pendingValid;
    logic [7:0]       capturedSample;
    logic             consume;
    logic [15:0]      frameWord;

    sync_rise_detect sampleClockEdge (
        .clock_50Mhz (clock_50Mhz),
        .reset_n     (reset_n),
        .asyncIn     (clock_22Khz),
        .risePulse   (tick)
    );

    assign capturedSample = mute ? AUDIO_MIDSCALE : sample_in;
    assign frameWord      = buildDacFrame(pendingSample, BUF_BIT);

    // IDLE takes the pending sample on the very cycle it sees it, so the
    // slot is free again at the next edge whether or not a new tick lands.
    assign consume = (state == IDLE) && pendingValid;

    // The pending slot holds one sample between its tick and the moment
    // the FSM starts sending it. A tick that lands while the slot is still
    // waiting for a busy transmitter replaces the older sample, since only
    // the most recent audio is worth playing, and the loss is counted. A
    // tick on the cycle IDLE empties the slot simply refills it.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            pendingSample <= 8'h00;
            pendingValid  <= 1'b0;
            overrun_count <= 8'h00;
        end else begin
            if (tick) begin
                pendingSample <= capturedSample;
                pendingValid  <= 1'b1;
                if (pendingValid && !consume && (overrun_count != 8'hFF)) begin
                    overrun_count <= overrun_count + 8'd1;
                end
            end else if (consume) begin
                pendingValid <= 1'b0;
            end
        end
    end

    // Frame sequencer. Every pin is driven straight from a flop and changes
    // only on a state or half-period boundary:
    //   IDLE  - load the frame, drop chip select, put bit 15 on MOSI
    //   SETUP - chip select settles before SCLK starts
    //   SHIFT - 16 periods, low half then high half; data moves on the
    //           falling edge so it is steady for a full half period on
    //           both sides of each rising edge the DAC samples on
    //   HOLD  - chip select held after the last fall, then released
    //   LDAC  - strobe the DAC latch so the new code reaches the output
    // An asynchronous reset mid-frame drops chip select and SCLK at once
    // and forgets the frame.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            downCount  <= '0;
            bitCount   <= 4'd0;
            shiftReg   <= 16'h0000;
            dac_sclk   <= 1'b0;
            dac_mosi   <= 1'b0;
            dac_cs_n   <= 1'b1;
            dac_ldac_n <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pendingValid) begin
                        shiftReg  <= frameWord;
                        dac_mosi  <= frameWord[15];
                        dac_cs_n  <= 1'b0;
                        busy      <= 1'b1;
                        downCount <= SETUP_LOAD;
                        state     <= SETUP;
                    end
                end

                SETUP: begin
                    if (downCount == '0) begin
                        bitCount  <= 4'd0;
                        downCount <= HALF_LOAD;
                        state     <= SHIFT;
                    end else begin
                        downCount <= downCount - CNT_W'(1);
                    end
                end

                SHIFT: begin
                    if (downCount != '0) begin
                        downCount <= downCount - CNT_W'(1);
                    end else if (!dac_sclk) begin
                        dac_sclk  <= 1'b1;
                        downCount <= HALF_LOAD;
                    end else begin
                        dac_sclk <= 1'b0;
                        if (bitCount == LAST_BIT) begin
                            downCount <= HOLD_LOAD;
                            state     <= HOLD;
                        end else begin
                            shiftReg  <= {shiftReg[14:0], 1'b0};
                            dac_mosi  <= shiftReg[14];
                            bitCount  <= bitCount + 4'd1;
                            downCount <= HALF_LOAD;
                        end
                    end
                end

                HOLD: begin
                    if (downCount == '0) begin
                        dac_cs_n   <= 1'b1;
                        dac_mosi   <= 1'b0;
                        dac_ldac_n <= 1'b0;
                        downCount  <= LDAC_LOAD;
                        state      <= LDAC;
                    end else begin
                        downCount <= downCount - CNT_W'(1);
                    end
                end

                LDAC: begin
                    if (downCount == '0) begin
                        dac_ldac_n <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        downCount <= downCount - CNT_W'(1);
                    end
                end

                default: begin
                    dac_sclk   <= 1'b0;
                    dac_mosi   <= 1'b0;
                    dac_cs_n   <= 1'b1;
                    dac_ldac_n <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_dac_spi_driver.sv
// ----------------------------------------------------------------------------
// tb_audio_dac_spi_driver
//
// Drives sample clock rises at known cycle numbers, decodes the SPI pins
// into frames, and compares against an event-level model of the capture
// slot and transmitter occupancy.
// ----------------------------------------------------------------------------
module tb_audio_dac_spi_driver;

    localparam int CLK_DIV    = 4;
    localparam int CS_SETUP   = 2;
    localparam int CS_HOLD    = 2;
    localparam int LDAC_WIDTH = 2;
    localparam bit BUF_BIT    = 1'b0;

    localparam int TICK_LATENCY = 3;
    localparam int CS_LOW_CYCLES = CS_SETUP + 32 * CLK_DIV + CS_HOLD;
    localparam int BUSY_CYCLES   = CS_LOW_CYCLES + LDAC_WIDTH;

    logic       clock_50Mhz = 1'b0;
    logic       reset_n;
    logic       clock_22Khz;
    logic [7:0] sample_in;
    logic       mute;
    logic       dac_sclk;
    logic       dac_mosi;
    logic       dac_cs_n;
    logic       dac_ldac_n;
    logic       busy;
    logic [7:0] overrun_count;

    int checks   = 0;
    int failures = 0;
    int edgeNow  = 0;

    audio_dac_spi_driver #(
        .CLK_DIV    (CLK_DIV),
        .CS_SETUP   (CS_SETUP),
        .CS_HOLD    (CS_HOLD),
        .LDAC_WIDTH (LDAC_WIDTH),
        .BUF_BIT    (BUF_BIT)
    ) dut (
        .clock_50Mhz   (clock_50Mhz),
        .reset_n       (reset_n),
        .clock_22Khz   (clock_22Khz),
        .sample_in     (sample_in),
        .mute          (mute),
        .dac_sclk      (dac_sclk),
        .dac_mosi      (dac_mosi),
        .dac_cs_n      (dac_cs_n),
        .dac_ldac_n    (dac_ldac_n),
        .busy          (busy),
        .overrun_count (overrun_count)
    );

    always #10 clock_50Mhz = ~clock_50Mhz;

    // Pin monitor, sampling on the falling edge of the system clock. It
    // shifts MOSI in on every SCLK rise and records each completed frame
    // together with the chip select, LDAC and busy pulse widths.
    logic [15:0] monWord = 16'h0000;
    int          monBits = 0;
    int          monCsLen = 0;
    int          monLdacLen = 0;
    int          monBusyLen = 0;
    int          monSclkViol = 0;
    int          monMosiViol = 0;
    logic        prevSclk = 1'b0;
    logic        prevCs = 1'b1;
    logic        prevLdac = 1'b1;
    logic        prevBusy = 1'b0;
    logic        prevMosi = 1'b0;
    logic [15:0] monFrames[$];
    int          monCsLens[$];
    int          monLdacLens[$];
    int          monBusyLens[$];

    always @(negedge clock_50Mhz) begin
        if (!reset_n) begin
            monBits    = 0;
            monCsLen   = 0;
            monLdacLen = 0;
            monBusyLen = 0;
            prevSclk   = 1'b0;
            prevCs     = 1'b1;
            prevLdac   = 1'b1;
            prevBusy   = 1'b0;
            prevMosi   = 1'b0;
        end else begin
            if (dac_sclk && dac_cs_n) monSclkViol++;
            if (dac_sclk && prevSclk && (dac_mosi !== prevMosi)) monMosiViol++;
            if (dac_sclk && !prevSclk) begin
                monWord = {monWord[14:0], dac_mosi};
                monBits++;
            end
            if (!dac_cs_n) monCsLen++;
            if (dac_cs_n && !prevCs) begin
                if (monBits == 16) begin
                    monFrames.push_back(monWord);
                    monCsLens.push_back(monCsLen);
                end
                monBits  = 0;
                monCsLen = 0;
            end
            if (!dac_ldac_n) monLdacLen++;
            if (dac_ldac_n && !prevLdac) begin
                monLdacLens.push_back(monLdacLen);
                monLdacLen = 0;
            end
            if (busy) monBusyLen++;
            if (!busy && prevBusy) begin
                monBusyLens.push_back(monBusyLen);
                monBusyLen = 0;
            end
            prevSclk = dac_sclk;
            prevCs   = dac_cs_n;
            prevLdac = dac_ldac_n;
            prevBusy = busy;
            prevMosi = dac_mosi;
        end
    end

    // Reference model. Each sample clock rise at edge R becomes a captured
    // sample at edge R + 3 + 1. The transmitter loads a waiting sample one
    // edge after capture, or as soon as it is free, and is then occupied for
    // the busy time plus the idle cycle in which it looks again. A capture
    // that arrives before the waiting sample was loaded replaces it.
    int          tickRise[$];
    logic [7:0]  tickSample[$];
    logic [15:0] expFrames[$];
    int          expOverrun;

    function automatic logic [15:0] frameOf(input logic [7:0] s);
        return 16'h3000 | (BUF_BIT ? 16'h4000 : 16'h0000) | (16'(s) << 4);
    endfunction

    task automatic runModel();
        int         freeEdge = 0;
        int         pendEdge = 0;
        logic [7:0] pendSample = 8'h00;
        bit         pendValid = 1'b0;
        int         loadEdge;
        int         capEdge;
        expFrames.delete();
        expOverrun = 0;
        for (int i = 0; i < tickRise.size(); i++) begin
            capEdge = tickRise[i] + TICK_LATENCY + 1;
            if (pendValid) begin
                loadEdge = (pendEdge + 1 > freeEdge) ? pendEdge + 1 : freeEdge;
                if (loadEdge <= capEdge) begin
                    expFrames.push_back(frameOf(pendSample));
                    freeEdge = loadEdge + BUSY_CYCLES + 1;
                end else begin
                    expOverrun++;
                end
            end
            pendSample = tickSample[i];
            pendValid  = 1'b1;
            pendEdge   = capEdge;
        end
        if (pendValid) expFrames.push_back(frameOf(pendSample));
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clock_50Mhz);
            edgeNow++;
        end
        #1;
    endtask

    task automatic clearRecords();
        monFrames.delete();
        monCsLens.delete();
        monLdacLens.delete();
        monBusyLens.delete();
        monSclkViol = 0;
        monMosiViol = 0;
        tickRise.delete();
        tickSample.delete();
    endtask

    task automatic doReset();
        clock_22Khz = 1'b0;
        reset_n     = 1'b0;
        stepCycles(3);
        reset_n = 1'b1;
        clearRecords();
        stepCycles(2);
    endtask

    task automatic applyStimulus(input logic [7:0] s, input logic m, input int gap);
        sample_in   = s;
        mute        = m;
        clock_22Khz = 1'b1;
        tickRise.push_back(edgeNow);
        tickSample.push_back(m ? 8'h80 : s);
        stepCycles(4);
        clock_22Khz = 1'b0;
        stepCycles(gap - 4);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        clock_22Khz = 1'b0;
        stepCycles(2);
        checks++; if (dac_sclk !== 1'b0) begin failures++; $display("[TB] FAIL resetSclk: got %b expected 0", dac_sclk); end
        checks++; if (dac_mosi !== 1'b0) begin failures++; $display("[TB] FAIL resetMosi: got %b expected 0", dac_mosi); end
        checks++; if (dac_cs_n !== 1'b1) begin failures++; $display("[TB] FAIL resetCsN: got %b expected 1", dac_cs_n); end
        checks++; if (dac_ldac_n !== 1'b1) begin failures++; $display("[TB] FAIL resetLdacN: got %b expected 1", dac_ldac_n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL resetBusy: got %b expected 0", busy); end
        checks++; if (overrun_count !== 8'h00) begin failures++; $display("[TB] FAIL resetOverrun: got %0d expected 0", overrun_count); end
        reset_n = 1'b1;
        clearRecords();
        stepCycles(2);
    endtask

    task automatic test_basic_frame();
        int          latency = 0;
        logic [15:0] got;
        int          gotLen;
        doReset();
        sample_in   = 8'hA5;
        mute        = 1'b0;
        clock_22Khz = 1'b1;
        tickRise.push_back(edgeNow);
        tickSample.push_back(8'hA5);
        for (int k = 1; k <= 10; k++) begin
            stepCycles(1);
            if (k == 4) clock_22Khz = 1'b0;
            if (latency == 0 && dac_cs_n === 1'b0) latency = k;
        end
        stepCycles(300);
        runModel();
        checks++; if (latency !== TICK_LATENCY + 2) begin failures++; $display("[TB] FAIL basicLatency: got %0d expected %0d", latency, TICK_LATENCY + 2); end
        got = (monFrames.size() > 0) ? monFrames[0] : 16'hxxxx;
        checks++; if (got !== 16'h3A50) begin failures++; $display("[TB] FAIL basicFrame: got %h expected 3a50", got); end
        checks++; if (monFrames.size() !== expFrames.size()) begin failures++; $display("[TB] FAIL basicCount: got %0d expected %0d", monFrames.size(), expFrames.size()); end
        gotLen = (monCsLens.size() > 0) ? monCsLens[0] : -1;
        checks++; if (gotLen !== CS_LOW_CYCLES) begin failures++; $display("[TB] FAIL basicCsLow: got %0d expected %0d", gotLen, CS_LOW_CYCLES); end
        gotLen = (monLdacLens.size() > 0) ? monLdacLens[0] : -1;
        checks++; if (gotLen !== LDAC_WIDTH) begin failures++; $display("[TB] FAIL basicLdac: got %0d expected %0d", gotLen, LDAC_WIDTH); end
        gotLen = (monBusyLens.size() > 0) ? monBusyLens[0] : -1;
        checks++; if (gotLen !== BUSY_CYCLES) begin failures++; $display("[TB] FAIL basicBusy: got %0d expected %0d", gotLen, BUSY_CYCLES); end
        checks++; if (monSclkViol !== 0) begin failures++; $display("[TB] FAIL basicSclkWhileCsHigh: got %0d expected 0", monSclkViol); end
        checks++; if (monMosiViol !== 0) begin failures++; $display("[TB] FAIL basicMosiStable: got %0d expected 0", monMosiViol); end
    endtask

    task automatic test_mute();
        logic [15:0] got;
        doReset();
        applyStimulus(8'hFF, 1'b1, 8);
        stepCycles(300);
        got = (monFrames.size() > 0) ? monFrames[0] : 16'hxxxx;
        checks++; if (got !== 16'h3800) begin failures++; $display("[TB] FAIL muteFrame: got %h expected 3800", got); end
        checks++; if (monFrames.size() !== 1) begin failures++; $display("[TB] FAIL muteCount: got %0d expected 1", monFrames.size()); end
        mute = 1'b0;
    endtask

    task automatic test_overrun();
        logic [15:0] got;
        doReset();
        applyStimulus(8'h11, 1'b0, 20);
        applyStimulus(8'h22, 1'b0, 20);
        applyStimulus(8'h33, 1'b0, 20);
        stepCycles(400);
        runModel();
        checks++; if (overrun_count !== 8'd1) begin failures++; $display("[TB] FAIL overrunCount: got %0d expected 1", overrun_count); end
        checks++; if (monFrames.size() !== expFrames.size()) begin failures++; $display("[TB] FAIL overrunFrames: got %0d expected %0d", monFrames.size(), expFrames.size()); end
        got = (monFrames.size() > 1) ? monFrames[1] : 16'hxxxx;
        checks++; if (got !== 16'h3330) begin failures++; $display("[TB] FAIL overrunSecond: got %h expected 3330", got); end
        for (int i = 0; i < expFrames.size(); i++) begin
            got = (i < monFrames.size()) ? monFrames[i] : 16'hxxxx;
            checks++; if (got !== expFrames[i]) begin failures++; $display("[TB] FAIL overrunFrame%0d: got %h expected %h", i, got, expFrames[i]); end
        end
    endtask

    task automatic test_same_cycle();
        logic [15:0] got;
        doReset();
        applyStimulus(8'h5A, 1'b0, 20);
        applyStimulus(8'hC3, 1'b0, 4 + CS_LOW_CYCLES - 20);
        applyStimulus(8'h3C, 1'b0, 20);
        stepCycles(400);
        runModel();
        checks++; if (overrun_count !== 8'd0) begin failures++; $display("[TB] FAIL sameCycleOverrun: got %0d expected 0", overrun_count); end
        checks++; if (monFrames.size() !== 3) begin failures++; $display("[TB] FAIL sameCycleCount: got %0d expected 3", monFrames.size()); end
        for (int i = 0; i < expFrames.size(); i++) begin
            got = (i < monFrames.size()) ? monFrames[i] : 16'hxxxx;
            checks++; if (got !== expFrames[i]) begin failures++; $display("[TB] FAIL sameCycleFrame%0d: got %h expected %h", i, got, expFrames[i]); end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [15:0] got;
        doReset();
        applyStimulus(8'h77, 1'b0, 8);
        for (int k = 0; k < 500 && monBits < 7; k++) stepCycles(1);
        checks++; if (monBits < 7) begin failures++; $display("[TB] FAIL midShiftReached: got %0d bits expected 7", monBits); end
        checks++; if (dac_cs_n !== 1'b0) begin failures++; $display("[TB] FAIL midShiftCsLow: got %b expected 0", dac_cs_n); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (dac_cs_n !== 1'b1) begin failures++; $display("[TB] FAIL midShiftCsN: got %b expected 1", dac_cs_n); end
        checks++; if (dac_sclk !== 1'b0) begin failures++; $display("[TB] FAIL midShiftSclk: got %b expected 0", dac_sclk); end
        checks++; if (dac_mosi !== 1'b0) begin failures++; $display("[TB] FAIL midShiftMosi: got %b expected 0", dac_mosi); end
        checks++; if (dac_ldac_n !== 1'b1) begin failures++; $display("[TB] FAIL midShiftLdacN: got %b expected 1", dac_ldac_n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midShiftBusy: got %b expected 0", busy); end
        stepCycles(2);
        reset_n = 1'b1;
        clearRecords();
        stepCycles(2);
        applyStimulus(8'h9C, 1'b0, 8);
        stepCycles(300);
        runModel();
        checks++; if (monFrames.size() !== 1) begin failures++; $display("[TB] FAIL afterResetCount: got %0d expected 1", monFrames.size()); end
        got = (monFrames.size() > 0) ? monFrames[0] : 16'hxxxx;
        checks++; if (got !== expFrames[0]) begin failures++; $display("[TB] FAIL afterResetFrame: got %h expected %h", got, expFrames[0]); end
        checks++; if (overrun_count !== 8'd0) begin failures++; $display("[TB] FAIL afterResetOverrun: got %0d expected 0", overrun_count); end
    endtask

    task automatic test_saturation();
        logic [15:0] got;
        logic [7:0]  expCount;
        doReset();
        for (int i = 0; i < 340; i++) applyStimulus(8'($urandom), 1'b0, 8);
        stepCycles(300);
        runModel();
        expCount = (expOverrun > 255) ? 8'd255 : 8'(expOverrun);
        checks++; if (overrun_count !== expCount) begin failures++; $display("[TB] FAIL saturation: got %0d expected %0d", overrun_count, expCount); end
        checks++; if (monFrames.size() !== expFrames.size()) begin failures++; $display("[TB] FAIL saturationFrames: got %0d expected %0d", monFrames.size(), expFrames.size()); end
        for (int i = 0; i < expFrames.size(); i++) begin
            got = (i < monFrames.size()) ? monFrames[i] : 16'hxxxx;
            checks++; if (got !== expFrames[i]) begin failures++; $display("[TB] FAIL saturationFrame%0d: got %h expected %h", i, got, expFrames[i]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] got;
        logic [7:0]  expCount;
        doReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(8, 300));
        end
        stepCycles(400);
        runModel();
        expCount = (expOverrun > 255) ? 8'd255 : 8'(expOverrun);
        checks++; if (overrun_count !== expCount) begin failures++; $display("[TB] FAIL randomOverrun: got %0d expected %0d", overrun_count, expCount); end
        checks++; if (monFrames.size() !== expFrames.size()) begin failures++; $display("[TB] FAIL randomFrames: got %0d expected %0d", monFrames.size(), expFrames.size()); end
        for (int i = 0; i < expFrames.size(); i++) begin
            got = (i < monFrames.size()) ? monFrames[i] : 16'hxxxx;
            checks++; if (got !== expFrames[i]) begin failures++; $display("[TB] FAIL randomFrame%0d: got %h expected %h", i, got, expFrames[i]); end
        end
        checks++; if (monSclkViol !== 0) begin failures++; $display("[TB] FAIL randomSclkWhileCsHigh: got %0d expected 0", monSclkViol); end
        mute = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        clock_22Khz = 1'b0;
        sample_in   = 8'h00;
        mute        = 1'b0;
        $display("[TB] audio_dac_spi_driver bench start");
        test_reset();
        test_basic_frame();
        test_mute();
        test_overrun();
        test_same_cycle();
        test_reset_mid_shift();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_dac_spi_driver.md
# audio_dac_spi_driver

- Takes the 8-bit unsigned audio sample from the music box state controller output (`outputAudioOutput`).
- Converts it to a 12-bit DAC code at each rising edge of the 22 kHz sample clock.
- Serialises the code as one 16-bit SPI frame (mode 0, MSB first) to an external single-channel 12-bit DAC, then pulses LDAC.
- Sits directly downstream of the state controller, between it and the DAC pins.

## Interface
Parameters:
- `CLK_DIV`, 4: SCLK half-period in `clock_50Mhz` cycles. Legal values ≥2. Default gives 6.25 MHz SCLK.
- `CS_SETUP`, 2: cycles from `dac_cs_n` low to the first SCLK rise.
- `CS_HOLD`, 2: cycles from the last SCLK fall to `dac_cs_n` high.
- `LDAC_WIDTH`, 2: `dac_ldac_n` low-pulse width in cycles.
- `BUF_BIT`, 0: value of frame bit 14 (DAC VREF buffer enable).

Ports:
- `clock_50Mhz`  in  1  system clock. Sole clock of the block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `clock_22Khz`  in  1  sample-rate clock from the divider. Treated as data: synchronised, then rising-edge detected.
- `sample_in`  in  8  unsigned audio sample. 0x80 is mid-scale.
- `mute`  in  1  when high, the captured sample is forced to 0x80.
- `dac_sclk`  out  1  SPI clock. Idles low.
- `dac_mosi`  out  1  SPI data.
- `dac_cs_n`  out  1  DAC chip select, active low.
- `dac_ldac_n`  out  1  DAC latch strobe, active low.
- `busy`  out  1  high in every state except IDLE.
- `overrun_count`  out  8  count of dropped samples. Saturates at 255.

## Operation
**Sample capture**
- `clock_22Khz` passes through a 2-FF synchroniser and a rising-edge detector, producing a 1-cycle `tick`.
- On `tick`: `pending` ← `mute ? 8'h80 : sample_in` and `pending_valid` ← 1.
- If `pending_valid` is already 1 and IDLE is not consuming it in the same cycle, the old sample is overwritten and `overrun_count` increments (saturating).

**Frame format** (16 bits, MSB first):
- bit 15 = 0 (channel A)
- bit 14 = `BUF_BIT`
- bit 13 = 1 (gain 1x)
- bit 12 = 1 (active)
- bits 11:0 = `{pending, 4'b0000}`

**State machine** (one-hot or binary, designer's choice):
- **IDLE**: all outputs at idle level. If `pending_valid` is set: load the shift register with the frame, clear `pending_valid`, set `dac_cs_n` = 0, go to SETUP.
  - A tick in this same cycle is captured into the freed slot and does not count as an overrun.
- **SETUP**: wait `CS_SETUP` cycles, then go to SHIFT. `dac_mosi` already presents bit 15.
- **SHIFT**: runs 16 bit periods of 2×`CLK_DIV` cycles each.
  - `dac_sclk` is low for the first `CLK_DIV` cycles of each period and high for the second.
  - On each SCLK fall, the shift register advances and `dac_mosi` presents the next bit.
  - After the 16th fall, go to HOLD.
- **HOLD**: wait `CS_HOLD` cycles, set `dac_cs_n` = 1, go to LDAC.
- **LDAC**: hold `dac_ldac_n` = 0 for `LDAC_WIDTH` cycles, then return to IDLE.

**Reset**
- Asserting `reset_n` clears everything immediately, including mid-frame. An aborted frame is not retransmitted.
- Reset values: `dac_sclk` = 0, `dac_mosi` = 0, `dac_cs_n` = 1, `dac_ldac_n` = 1, `busy` = 0, `overrun_count` = 0, `pending_valid` = 0, synchroniser flops = 0, state = IDLE.

## Timing
- All outputs are registered; no combinational path from any input to any pin.
- Latency:
  - `clock_22Khz` rise → `tick`: 3 cycles.
  - `tick` → `dac_cs_n` low: 2 cycles when idle.
- `dac_cs_n` low duration = `CS_SETUP` + 32×`CLK_DIV` + `CS_HOLD` = 132 cycles at defaults.
- Total `busy` time per frame = 134 cycles at defaults, far below the 2272-cycle sample period. Overrun occurs only if `CLK_DIV` is very large or `clock_22Khz` glitches.
- SPI mode 0:
  - `dac_mosi` is stable ≥`CLK_DIV` cycles before and after each SCLK rise.
  - SCLK is never high while `dac_cs_n` = 1.

## Structure
- Shared package `music_box_pkg` holds:
  - the `dac_state_t` enum (IDLE, SETUP, SHIFT, HOLD, LDAC);
  - frame config constants (`DAC_CH_A`, `DAC_GAIN_1X`, `DAC_ACTIVE`);
  - `AUDIO_MIDSCALE` = 8'h80.
- Sub-module `sync_rise_detect`: 2-FF synchroniser plus previous-value register, outputs a 1-cycle pulse. It is reusable for the button and clock-domain inputs elsewhere.
- Implementation is a single FSM with one shared down-counter for setup/half-period/hold/ldac timing, plus a 4-bit bit counter.

## Test plan
- **Basic frame**: `sample_in` = 8'hA5, one `clock_22Khz` rise → MOSI bits 0011_1010_0101_0000 (0x3A50) across 16 SCLK rises; `dac_cs_n` low for 132 cycles; then `dac_ldac_n` low for 2 cycles.
- **Mute**: `mute` = 1, `sample_in` = 8'hFF → frame 0x3800.
- **Overrun**: 3 ticks forced 20 cycles apart while busy with samples 0x11/0x22/0x33 → second frame carries 0x33; `overrun_count` = 1.
- **Same-cycle consume and capture**: tick on the exact cycle IDLE loads → `overrun_count` stays 0; both samples are transmitted in order.
- **Reset mid-SHIFT**: `reset_n` low at bit 7 → `dac_cs_n` = 1 and `dac_sclk` = 0 in the same cycle, all outputs at reset values; after release, the next tick produces a complete frame.
- **Saturation**: 300 forced overruns → `overrun_count` holds at 255.
